// File: rtl/inference_sequencer.sv
// Host-side sequencer for the inference wrapper: loads sample words, arms the
// read/count timers, and returns the wrapper result (or a timeout error) to the host.
//
// state        | meaning
// S_IDLE       | waiting for start; configuration latched on start
// S_LOAD       | streaming sample words to the wrapper as write opcodes
// S_INFO       | one info opcode carrying the read/count timer values
// S_WAIT_BUSY  | waiting for the wrapper to report busy
// S_WAIT_DONE  | waiting for the wrapper to report idle-with-result
// S_RESULT     | holding the captured result until the host takes it
module inference_sequencer #(
    parameter int DATA_W = 19,
    parameter int RES_W  = 7,
    parameter int CNT_W  = 8,
    parameter int TO_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic [CNT_W-1:0]  cfg_read,
    input  logic [CNT_W-1:0]  cfg_count,
    output logic              busy,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [1:0]        opcode_o,
    output logic [DATA_W-1:0] data_o,
    input  logic [1:0]        status_i,
    input  logic [RES_W-1:0]  result_i,
    output logic              res_valid,
    output logic [RES_W-1:0]  res_data,
    input  logic              res_ready,
    output logic              err_o
);
    localparam logic [1:0] OP_IDLE   = 2'd0;
    localparam logic [1:0] OP_WRITE  = 2'd1;
    localparam logic [1:0] OP_INFO   = 2'd2;
    localparam logic [1:0] ST_BUSY   = 2'd1;
    localparam logic [1:0] ST_RESULT = 2'd2;
    localparam int INFO_CNT_LSB = 10;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_INFO, S_WAIT_BUSY, S_WAIT_DONE, S_RESULT
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   len_cnt, len_n;
    logic [CNT_W-1:0]   read_q, read_n;
    logic [CNT_W-1:0]   count_q, count_n;
    logic [TO_W-1:0]    to_cnt, to_n;
    logic [1:0]         opcode_n;
    logic [DATA_W-1:0]  data_n;
    logic               res_valid_n;
    logic [RES_W-1:0]   res_data_n;
    logic               err_n;
    logic [CNT_W:0]     timer_sum;

    assign busy    = (state != S_IDLE);
    assign s_ready = (state == S_LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            len_cnt   <= '0;
            read_q    <= '0;
            count_q   <= '0;
            to_cnt    <= '0;
            opcode_o  <= OP_IDLE;
            data_o    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            err_o     <= 1'b0;
        end else begin
            state     <= state_n;
            len_cnt   <= len_n;
            read_q    <= read_n;
            count_q   <= count_n;
            to_cnt    <= to_n;
            opcode_o  <= opcode_n;
            data_o    <= data_n;
            res_valid <= res_valid_n;
            res_data  <= res_data_n;
            err_o     <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        len_n       = len_cnt;
        read_n      = read_q;
        count_n     = count_q;
        to_n        = to_cnt;
        opcode_n    = OP_IDLE;
        data_n      = '0;
        res_valid_n = res_valid;
        res_data_n  = res_data;
        err_n       = 1'b0;
        timer_sum   = {1'b0, read_q} + {1'b0, count_q};

        case (state)
            S_IDLE: begin
                if (start) begin
                    len_n   = cfg_len;
                    read_n  = cfg_read;
                    count_n = cfg_count;
                    state_n = (cfg_len != '0) ? S_LOAD : S_INFO;
                end
            end
            S_LOAD: begin
                if (s_valid) begin
                    opcode_n = OP_WRITE;
                    data_n   = s_data;
                    len_n    = len_cnt - 1'b1;
                    if (len_cnt == CNT_W'(1)) state_n = S_INFO;
                end
            end
            S_INFO: begin
                opcode_n = OP_INFO;
                data_n[CNT_W-1:0]             = read_q;
                data_n[INFO_CNT_LSB +: CNT_W] = count_q;
                to_n     = '0;
                // Zero timers: the wrapper never goes busy, so skip straight to the result wait.
                state_n  = (timer_sum == '0) ? S_WAIT_DONE : S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (status_i == ST_BUSY) begin
                    state_n = S_WAIT_DONE;
                    to_n    = '0;
                end else if (to_cnt == '1) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    to_n = to_cnt + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (status_i == ST_RESULT) begin
                    res_data_n  = result_i;
                    res_valid_n = 1'b1;
                    state_n     = S_RESULT;
                end else if (to_cnt == '1) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    to_n = to_cnt + 1'b1;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    res_valid_n = 1'b0;
                    state_n     = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_inference_sequencer.sv
// Randomized scoreboard bench for inference_sequencer with a simple wrapper model;
// a negedge monitor checks every wrapper opcode, result and error against queued expectations.
module tb_inference_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  cfg_len, cfg_read, cfg_count;
    logic        busy;
    logic        s_valid;
    logic [18:0] s_data;
    logic        s_ready;
    logic [1:0]  opcode_o;
    logic [18:0] data_o;
    logic [1:0]  status_i;
    logic [6:0]  result_i;
    logic        res_valid;
    logic [6:0]  res_data;
    logic        res_ready;
    logic        err_o;

    inference_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_read(cfg_read),
        .cfg_count(cfg_count), .busy(busy), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .opcode_o(opcode_o), .data_o(data_o), .status_i(status_i),
        .result_i(result_i), .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [20:0] exp_ops[$];
    logic [6:0]  exp_res[$];
    int          exp_err[$];
    logic [18:0] words[$];

    int          wr_mode = 0;      // 0 normal, 1 zero timers (no busy), 2 dead
    int          wr_busy = 1;
    logic [6:0]  wr_result = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations as the DUT presents outputs
    int   info_cyc = 0;
    logic rv_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            rv_prev <= 1'b0;
        end else begin
            if (opcode_o != 2'd0) begin
                if (exp_ops.size() == 0) chk("op_unexpected", 32'({opcode_o, data_o}), 32'h0);
                else chk("op_word", 32'({opcode_o, data_o}), 32'(exp_ops.pop_front()));
                if (opcode_o == 2'd2) info_cyc = cyc;
            end else begin
                chk("data_zero_when_idle_op", 32'(data_o), 32'h0);
            end
            if (res_valid && !rv_prev) begin
                if (exp_res.size() == 0) chk("res_unexpected", 32'(res_data), 32'hFFFF);
                else chk("res_data", 32'(res_data), 32'(exp_res.pop_front()));
            end
            if (err_o) begin
                if (exp_err.size() == 0) chk("err_unexpected", 32'(err_o), 32'h0);
                else begin
                    void'(exp_err.pop_front());
                    chk("timeout_window", 32'((cyc - info_cyc >= 1023) && (cyc - info_cyc <= 1025)), 32'h1);
                end
            end
            rv_prev <= res_valid;
        end
    end

    // Wrapper model: goes busy after the info opcode, then reports a result
    initial begin
        status_i = 2'd0;
        result_i = '0;
        forever begin
            @(negedge clk);
            if (!rst && opcode_o == 2'd2 && wr_mode != 2) begin
                if (wr_mode == 0) begin
                    status_i = 2'd1;
                    repeat (wr_busy) @(negedge clk);
                end else begin
                    repeat (3) @(negedge clk);
                end
                status_i = 2'd2;
                result_i = wr_result;
                for (int k = 0; k < 5000 && busy; k++) @(negedge clk);
                status_i = 2'd0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int len, input int rd, input int ct);
        start = 1'b1;
        cfg_len = 8'(len); cfg_read = 8'(rd); cfg_count = 8'(ct);
        tick();
        start = 1'b0;
        cfg_len = 8'($urandom); cfg_read = 8'($urandom); cfg_count = 8'($urandom);
    endtask

    task automatic send_word(input logic [18:0] w);
        int n;
        repeat ($urandom_range(0, 2)) tick();
        s_valid = 1'b1;
        s_data  = w;
        n = 0;
        while (!s_ready && n < 100) begin tick(); n++; end
        if (n == 100) chk("s_ready_timeout", 32'(s_ready), 32'h1);
        tick();
        s_valid = 1'b0;
        s_data  = 19'($urandom);
    endtask

    // One full run; words come from the global queue
    task automatic run(input int rd, input int ct, input int mode, input int busy_n,
                       input logic [6:0] res, input int hold);
        int n;
        int len;
        len = words.size();
        wr_mode = mode; wr_busy = busy_n; wr_result = res;
        chk("idle_before_start", 32'(busy), 32'h0);
        foreach (words[i]) exp_ops.push_back({2'd1, words[i]});
        exp_ops.push_back({2'd2, 19'(ct * 1024 + rd)});
        if (mode == 2) exp_err.push_back(1);
        else exp_res.push_back(res);

        start_run(len, rd, ct);
        chk("busy_after_start", 32'(busy), 32'h1);
        for (int i = 0; i < len; i++) send_word(words[i]);
        chk("s_ready_after_last", 32'(s_ready), 32'h0);
        // Stray valid data must not be accepted once loading is done
        s_valid = 1'b1;
        repeat (3) tick();
        s_valid = 1'b0;

        n = 0;
        while (!res_valid && !err_o && n < 3000) begin tick(); n++; end
        if (mode == 2) begin
            chk("err_pulse", 32'(err_o), 32'h1);
            chk("no_res_on_timeout", 32'(res_valid), 32'h0);
            tick();
            chk("err_one_cycle", 32'(err_o), 32'h0);
            chk("idle_after_timeout", 32'(busy), 32'h0);
        end else begin
            chk("res_valid_seen", 32'(res_valid), 32'h1);
            for (int h = 0; h < hold; h++) begin
                tick();
                chk("hold_valid", 32'(res_valid), 32'h1);
                chk("hold_data", 32'(res_data), 32'(res));
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            chk("res_valid_drop", 32'(res_valid), 32'h0);
            chk("idle_after_result", 32'(busy), 32'h0);
        end
        chk("ops_drained", 32'(exp_ops.size()), 32'h0);
        chk("res_drained", 32'(exp_res.size()), 32'h0);
        chk("err_drained", 32'(exp_err.size()), 32'h0);
        words.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int rd, ct, len;
        rst = 1'b1; start = 1'b1; s_valid = 1'b1; s_data = 19'h5A5A5;
        cfg_len = 8'd3; cfg_read = 8'd1; cfg_count = 8'd1; res_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_s_ready", 32'(s_ready), 32'h0);
            chk("rst_opcode", 32'(opcode_o), 32'h0);
            chk("rst_data", 32'(data_o), 32'h0);
            chk("rst_res_valid", 32'(res_valid), 32'h0);
            chk("rst_res_data", 32'(res_data), 32'h0);
            chk("rst_err", 32'(err_o), 32'h0);
        end
        rst = 1'b0; start = 1'b0; s_valid = 1'b0;

        // Directed load of three words, long busy, delayed host accept
        words.push_back(19'h00001); words.push_back(19'h7FFFF); words.push_back(19'h12345);
        run(5, 15, 0, 20, 7'h2A, 4);

        // Zero length and zero timers: wrapper never goes busy
        run(0, 0, 1, 1, 7'h55, 1);

        // Dead wrapper: timeout abort
        words.push_back(19'($urandom)); words.push_back(19'($urandom));
        run(3, 4, 2, 1, 7'h00, 0);

        // Reset during LOAD after one of four words
        wr_mode = 2;
        exp_ops.push_back({2'd1, 19'h0ABCD});
        start_run(4, 9, 9);
        send_word(19'h0ABCD);
        @(negedge clk);
        #1 rst = 1'b1;
        tick();
        chk("rst_load_opcode", 32'(opcode_o), 32'h0);
        chk("rst_load_s_ready", 32'(s_ready), 32'h0);
        chk("rst_load_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        tick();
        chk("rst_load_ops_drained", 32'(exp_ops.size()), 32'h0);
        words.push_back(19'($urandom)); words.push_back(19'($urandom));
        run(2, 7, 0, 6, 7'h13, 2);

        // Randomized runs
        for (int r = 0; r < 10; r++) begin
            len = $urandom_range(0, 5);
            for (int i = 0; i < len; i++) words.push_back(19'($urandom));
            if ($urandom_range(0, 3) == 0) begin rd = 0; ct = 0; end
            else begin rd = $urandom_range(0, 255); ct = $urandom_range(1, 255); end
            run(rd, ct, (rd + ct == 0) ? 1 : 0, $urandom_range(1, 25),
                7'($urandom), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/inference_sequencer.md
Name: inference_sequencer

Overview:
Host-side controller for the inference wrapper. It accepts a start command with load length and timer settings, then streams sample words into the wrapper memory with write opcodes. It then issues one info opcode that arms the read and count timers, waits for the wrapper to go busy and then report idle-with-result, and returns the result to the host over a valid/ready interface. A timeout watchdog aborts a run if the wrapper never reports a result.

Parameters:
DATA_W, 19, sample word width; equals the wrapper data_in width
RES_W, 7, result width; equals the wrapper result_o width
CNT_W, 8, width of the length, read-timer and count-timer fields
TO_W, 10, timeout counter width; a run aborts after 2^TO_W-1 wait cycles

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous reset, active-high
start  in  1  run request; sampled only in IDLE
cfg_len  in  CNT_W  number of sample words to load
cfg_read  in  CNT_W  read-timer value
cfg_count  in  CNT_W  count-timer value
busy  out  1  high in every state except IDLE
s_valid  in  1  sample word valid
s_data  in  DATA_W  sample word
s_ready  out  1  sequencer accepts a sample
opcode_o  out  2  to wrapper opcode: 0 idle, 1 write, 2 info
data_o  out  DATA_W  to wrapper data_in
status_i  in  2  from wrapper status: 0 idle, 1 busy, 2 idle with result
result_i  in  RES_W  from wrapper result
res_valid  out  1  result available
res_data  out  RES_W  captured result
res_ready  in  1  host accepts the result
err_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: state IDLE. busy, s_ready, res_valid, err_o, opcode_o, data_o, res_data and all counters are 0.
- opcode_o and data_o are registered. data_o is 0 whenever opcode_o is 0.
- States: IDLE, LOAD, INFO, WAIT_BUSY, WAIT_DONE, RESULT.
- IDLE:
  - On start, latch cfg_len, cfg_read and cfg_count.
  - Go to LOAD if cfg_len != 0, otherwise go to INFO.
  - start is ignored in every other state.
- LOAD:
  - s_ready = 1.
  - On each s_valid && s_ready handshake, the next cycle has opcode_o = 1 and data_o = s_data, and the remaining-word count is decremented.
  - Cycles without a handshake drive opcode_o = 0. The host may stall indefinitely; there is no timeout in LOAD.
  - s_ready drops in the cycle after the last handshake, so no extra word is accepted. Next state is INFO.
  - The wrapper memory wraps at its depth. A cfg_len larger than the memory depth is legal and overwrites older words; the sequencer does not check it.
- INFO:
  - Exactly one cycle with opcode_o = 2.
  - data_o bits [17:10] = cfg_count, bits [7:0] = cfg_read, all other bits 0.
  - If cfg_read + cfg_count == 0 (9-bit sum), go to WAIT_DONE, because the wrapper never reports busy in that case. Otherwise go to WAIT_BUSY.
- WAIT_BUSY: advance to WAIT_DONE when status_i == 1.
- WAIT_DONE: on status_i == 2, capture result_i into res_data, set res_valid = 1 and go to RESULT. status_i == 0 and status_i == 1 both keep waiting.
- Timeout:
  - A single counter is cleared on entry to WAIT_BUSY and on entry to WAIT_DONE, and increments each cycle spent in either state.
  - At all-ones: pulse err_o for one cycle, do not assert res_valid, and return to IDLE.
- RESULT:
  - res_valid and res_data are held stable until res_ready.
  - On handshake, res_valid = 0 the next cycle and the state returns to IDLE.
  - A new start is accepted no earlier than the cycle after the return to IDLE.
- Reset mid-operation: return to IDLE immediately, drop any pending result, opcode_o = 0.
- Latency, cfg_len = 0 case: start to the INFO opcode is 2 cycles (IDLE, INFO).

Test Plan:
- Reset held 3 cycles with start = 1 and s_valid = 1 -> all outputs 0, state stays IDLE. Release reset -> start is accepted.
- cfg_len = 3, words 0x00001, 0x7FFFF, 0x12345 with s_valid gaps -> opcode_o = 1 exactly 3 times with those data values, followed by one opcode_o = 2 with data_o = 0x03C05 for cfg_read = 5, cfg_count = 15.
- Wrapper model: busy for 20 cycles, then status = 2 with result = 0x2A; hold res_ready low for 4 cycles -> res_data = 0x2A held stable, res_valid drops the cycle after res_ready, and busy falls.
- cfg_len = 0, cfg_read = 0, cfg_count = 0 -> INFO data_o = 0, the sequencer skips WAIT_BUSY, and the result is captured on status = 2.
- Wrapper never leaves status 0 -> err_o pulses once after 1023 wait cycles, res_valid never rises, and the state returns to IDLE.
- rst asserted during LOAD after 1 of 4 words -> opcode_o = 0 and s_ready = 0 next cycle; a fresh run then completes normally.
